// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter: FSM state encoding
// and frame-length helper.
package parity_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_t;

   // Start bit + data bits + parity bit + stop bit
   function automatic int FRAME_BITS(input int width);
      return width + 3;
   endfunction

endpackage

// File: rtl/parity_frame_tx_baud_tick_gen.sv
// Baud-rate divider: pulses bit_tick on the last cycle of every BAUD_DIV-cycle
// bit period; clear restarts the period so bit timing aligns to acceptance.
module baud_tick_gen #(
   parameter int BAUD_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (clear || (count_q == LAST_COUNT)) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bit_tick = (count_q == LAST_COUNT);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1), with the
// parity bit taken from the upstream generator's even/odd flags.
module parity_frame_tx
   import parity_tx_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int BAUD_DIV   = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             even_parity_in,
   input  logic             odd_parity_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             tx_out,
   output logic             busy,
   output logic             frame_done,
   output logic             par_in_err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   txState_t         state_q;
   txState_t         state_d;
   logic [WIDTH-1:0] shift_q;
   logic [IDX_W-1:0] bitIdx_q;
   logic             parityBit_q;
   logic             parErr_q;
   logic             transfer;
   logic             bitTick;

   assign in_ready = (state_q == IDLE) & ~rst;
   assign transfer = in_valid & in_ready;
   assign par_in_err = parErr_q;

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (transfer),
      .bit_tick (bitTick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (transfer) state_d = START;
         START:   if (bitTick) state_d = DATA;
         DATA:    if (bitTick && (bitIdx_q == LAST_IDX)) state_d = PARITY;
         PARITY:  if (bitTick) state_d = STOP;
         STOP:    if (bitTick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_out     = 1'b1;
      busy       = 1'b1;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE:    busy = 1'b0;
         START:   tx_out = 1'b0;
         DATA:    tx_out = shift_q[0];
         PARITY:  tx_out = parityBit_q;
         STOP:    frame_done = bitTick;
         default: busy = 1'b0;
      endcase
   end

   // Word and parity are frozen at acceptance; later input changes cannot leak in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q     <= '0;
         bitIdx_q    <= '0;
         parityBit_q <= 1'b0;
         parErr_q    <= 1'b0;
      end else if (transfer) begin
         shift_q     <= data_in;
         bitIdx_q    <= '0;
         parityBit_q <= (PARITY_ODD != 0) ? even_parity_in : odd_parity_in;
         parErr_q    <= (even_parity_in == odd_parity_in);
      end else if ((state_q == DATA) && bitTick) begin
         shift_q  <= shift_q >> 1;
         bitIdx_q <= bitIdx_q + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: three instances cover even/odd parity
// frames and the minimal WIDTH=1/BAUD_DIV=1 corner.
module tb_parity_frame_tx;
   import parity_tx_pkg::*;

   typedef struct {
      int         dut;
      int         len;
      logic [15:0] bits;
      logic       err;
   } expFrame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dataIn = 8'h00;
   logic       evenIn = 1'b0;
   logic       oddIn = 1'b0;
   logic [2:0] inValid = 3'b000;
   logic [2:0] inReady;
   logic [2:0] txOut;
   logic [2:0] busy;
   logic [2:0] frameDone;
   logic [2:0] parErr;

   int checks = 0;
   int errors = 0;
   expFrame_t expQ[$];
   int baudOf[3] = '{4, 4, 1};
   logic [63:0] samples[3];
   int sampleCnt[3] = '{0, 0, 0};

   always #5 clk = ~clk;

   parity_frame_tx #(.WIDTH(8), .BAUD_DIV(4), .PARITY_ODD(0)) dutEven (
      .clk(clk), .rst(rst), .data_in(dataIn), .even_parity_in(evenIn),
      .odd_parity_in(oddIn), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .tx_out(txOut[0]), .busy(busy[0]), .frame_done(frameDone[0]),
      .par_in_err(parErr[0])
   );

   parity_frame_tx #(.WIDTH(8), .BAUD_DIV(4), .PARITY_ODD(1)) dutOdd (
      .clk(clk), .rst(rst), .data_in(dataIn), .even_parity_in(evenIn),
      .odd_parity_in(oddIn), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .tx_out(txOut[1]), .busy(busy[1]), .frame_done(frameDone[1]),
      .par_in_err(parErr[1])
   );

   parity_frame_tx #(.WIDTH(1), .BAUD_DIV(1), .PARITY_ODD(0)) dutTiny (
      .clk(clk), .rst(rst), .data_in(dataIn[0:0]), .even_parity_in(evenIn),
      .odd_parity_in(oddIn), .in_valid(inValid[2]), .in_ready(inReady[2]),
      .tx_out(txOut[2]), .busy(busy[2]), .frame_done(frameDone[2]),
      .par_in_err(parErr[2])
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits for in_ready, transfers one word, optionally queues its expected frame,
   // then confirms the start bit appears the cycle after the transfer edge.
   task automatic applyStimulus(input int dut, input logic [7:0] d, input logic ev,
                                input logic od, input bit push, input int len,
                                input logic [15:0] bits, input logic err);
      int waitCycles = 0;
      expFrame_t e;
      @(negedge clk);
      while (!inReady[dut] && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("in_ready before send", {31'd0, inReady[dut]}, 32'd1);
      dataIn = d;
      evenIn = ev;
      oddIn = od;
      inValid[dut] = 1'b1;
      if (push) begin
         e.dut = dut;
         e.len = len;
         e.bits = bits;
         e.err = err;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      inValid[dut] = 1'b0;
      @(negedge clk);
      checkOutput("start latency busy", {31'd0, busy[dut]}, 32'd1);
      checkOutput("start latency tx", {31'd0, txOut[dut]}, 32'd0);
   endtask

   task automatic waitFrameDone(input int dut);
      int n = 0;
      while (!frameDone[dut] && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame_done seen", {31'd0, frameDone[dut]}, 32'd1);
   endtask

   // Monitor: collects one tx sample per busy cycle and scores the whole frame
   // against the queued expectation when frame_done appears.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            sampleCnt[k] = 0;
         end else begin
            if (busy[k] && sampleCnt[k] < 64) begin
               samples[k][sampleCnt[k]] = txOut[k];
               sampleCnt[k]++;
            end
            if (frameDone[k]) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected frame_done on dut %0d: got pulse expected none", k);
               end else begin
                  expFrame_t e;
                  int bad;
                  e = expQ.pop_front();
                  bad = -1;
                  checkOutput("frame dut id", k, e.dut);
                  checkOutput("frame length cycles", sampleCnt[k], e.len * baudOf[k]);
                  for (int i = 0; i < e.len * baudOf[k] && i < sampleCnt[k]; i++) begin
                     if (bad < 0 && samples[k][i] !== e.bits[e.len - 1 - i / baudOf[k]]) begin
                        bad = i;
                     end
                  end
                  checks++;
                  if (bad >= 0) begin
                     errors++;
                     $display("[TB] FAIL frame bits dut %0d: cycle %0d got %0b expected %0b",
                              k, bad, samples[k][bad], e.bits[e.len - 1 - bad / baudOf[k]]);
                  end
                  checkOutput("par_in_err", {31'd0, parErr[k]}, {31'd0, e.err});
               end
               sampleCnt[k] = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset tx_out", {29'd0, txOut}, 32'h7);
      checkOutput("reset busy", {29'd0, busy}, 32'h0);
      checkOutput("reset frame_done", {29'd0, frameDone}, 32'h0);
      checkOutput("reset par_in_err", {29'd0, parErr}, 32'h0);
      checkOutput("reset in_ready", {29'd0, inReady}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle in_ready", {29'd0, inReady}, 32'h7);

      // 0xA5 even frame: 44-cycle frame, parity bit = odd flag (0)
      applyStimulus(0, 8'hA5, 1'b1, 1'b0, 1'b1, FRAME_BITS(8), 16'b01010010101, 1'b0);
      waitFrameDone(0);

      // 0x07 on odd-parity instance: parity bit = even flag (0)
      applyStimulus(1, 8'h07, 1'b0, 1'b1, 1'b1, FRAME_BITS(8), 16'b01110000001, 1'b0);
      waitFrameDone(1);

      // in_valid held high: 0x00 then 0xFF with exactly one idle cycle between
      @(negedge clk);
      dataIn = 8'h00;
      evenIn = 1'b1;
      oddIn = 1'b0;
      inValid[0] = 1'b1;
      expQ.push_back('{0, 11, 16'b00000000001, 1'b0});
      expQ.push_back('{0, 11, 16'b01111111101, 1'b0});
      n = 0;
      while (!busy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      dataIn = 8'hFF;
      waitFrameDone(0);
      @(negedge clk);
      checkOutput("gap tx idle", {31'd0, txOut[0]}, 32'd1);
      checkOutput("gap busy", {31'd0, busy[0]}, 32'd0);
      checkOutput("gap in_ready", {31'd0, inReady[0]}, 32'd1);
      @(negedge clk);
      checkOutput("second start busy", {31'd0, busy[0]}, 32'd1);
      checkOutput("second start tx", {31'd0, txOut[0]}, 32'd0);
      waitFrameDone(0);
      @(negedge clk);
      inValid[0] = 1'b0;

      // Reset during data bit 3: frame abandoned, no frame_done
      applyStimulus(0, 8'h5A, 1'b1, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("mid reset tx_out", {31'd0, txOut[0]}, 32'd1);
      checkOutput("mid reset busy", {31'd0, busy[0]}, 32'd0);
      checkOutput("mid reset in_ready", {31'd0, inReady[0]}, 32'd0);
      @(negedge clk);
      checkOutput("held reset in_ready", {31'd0, inReady[0]}, 32'd0);
      rst = 1'b0;
      applyStimulus(0, 8'h3C, 1'b1, 1'b0, 1'b1, FRAME_BITS(8), 16'b00011110001, 1'b0);
      waitFrameDone(0);

      // Non-complementary flags: error flagged, parity bit from odd flag
      applyStimulus(0, 8'h01, 1'b1, 1'b1, 1'b1, FRAME_BITS(8), 16'b01000000011, 1'b1);
      waitFrameDone(0);
      applyStimulus(0, 8'h03, 1'b1, 1'b0, 1'b1, FRAME_BITS(8), 16'b01100000001, 1'b0);
      waitFrameDone(0);

      // WIDTH=1, BAUD_DIV=1: four-cycle frame 0,1,1,1
      applyStimulus(2, 8'h01, 1'b0, 1'b1, 1'b1, FRAME_BITS(1), 16'b0111, 1'b0);
      waitFrameDone(2);

      repeat (3) @(negedge clk);
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("scoreboard drained", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
